// File: rtl/othello_cursor_datapath_if.sv
// othello_cursor_datapath_if: plot-job valid/ready bus between the cursor datapath and the drawing engine
interface othello_cursor_datapath_if #(
  parameter int XPW = 8,
  parameter int YPW = 7
);
  logic [XPW-1:0] x_plot;
  logic [YPW-1:0] y_plot;
  logic [1:0]     select;
  logic           plot_valid;
  logic           plot_ready;
  modport master (output x_plot, y_plot, select, plot_valid, input plot_ready);
  modport slave (input x_plot, y_plot, select, plot_valid, output plot_ready);
endinterface

// File: rtl/othello_cursor_datapath.sv
// othello_cursor_datapath: board cursor, side, cell array and plot-job sequencer; OTHELLO_INIT_BOARD_EN loads the opening position at reset
module othello_cursor_datapath #(
  parameter int BOARD_DIM = 8,
  parameter int CW        = 3,
  parameter int PITCH     = 13,
  parameter int X_ORIGIN  = 9,
  parameter int Y_ORIGIN  = 9,
  parameter int XPW       = 8,
  parameter int YPW       = 7,
  parameter int WRAP      = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  i_move_up,
  input  logic                  i_move_down,
  input  logic                  i_move_left,
  input  logic                  i_move_right,
  input  logic                  i_turn_side,
  input  logic                  i_place_disk,
  input  logic [CW-1:0]         i_rd_x,
  input  logic [CW-1:0]         i_rd_y,
  output logic [1:0]            o_rd_state,
  output logic [CW-1:0]         o_x,
  output logic [CW-1:0]         o_y,
  output logic [CW-1:0]         o_old_x,
  output logic [CW-1:0]         o_old_y,
  output logic                  o_side,
  output logic                  o_place_reject,
  output logic                  o_busy,
  othello_cursor_datapath_if.master plot_if
);
  localparam int NCELL = BOARD_DIM * BOARD_DIM;
  localparam int IW = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam logic [CW-1:0] MAXC = CW'(BOARD_DIM - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_BOX   = 2'd2;
  localparam logic [1:0] S_DISK  = 2'd3;
`ifdef OTHELLO_INIT_BOARD_EN
  localparam int M = BOARD_DIM / 2;
  localparam logic [IW-1:0] I_LL = IW'((M - 1) * BOARD_DIM + (M - 1));
  localparam logic [IW-1:0] I_HH = IW'(M * BOARD_DIM + M);
  localparam logic [IW-1:0] I_HL = IW'((M - 1) * BOARD_DIM + M);
  localparam logic [IW-1:0] I_LH = IW'(M * BOARD_DIM + (M - 1));
`endif

  logic [1:0]     r_state;
  logic [CW-1:0]  r_x, r_y, r_old_x, r_old_y;
  logic           r_side;
  logic           r_mv_d, r_turn_d, r_place_d;
  logic [XPW-1:0] r_xp;
  logic [YPW-1:0] r_yp;
  logic [1:0]     r_sel;
  logic           r_pv;
  logic           r_rej;
  logic [1:0]     r_cells [NCELL];

  logic           w_mv_any, w_mv_ev, w_turn_ev, w_place_ev, w_idle, w_moved, w_place_go, w_rd_in;
  logic [CW-1:0]  w_nx, w_ny;
  logic [IW-1:0]  w_cur_idx, w_rd_idx;
  logic [1:0]     w_cell_cur;
  logic [XPW-1:0] w_xp;
  logic [YPW-1:0] w_yp;

  function automatic logic [CW-1:0] f_dec(input logic [CW-1:0] v);
    return (v == '0) ? ((WRAP != 0) ? MAXC : v) : v - CW'(1);
  endfunction

  function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
    return (v == MAXC) ? ((WRAP != 0) ? '0 : v) : v + CW'(1);
  endfunction

  assign w_mv_any   = i_move_up | i_move_down | i_move_left | i_move_right;
  assign w_mv_ev    = w_mv_any & ~r_mv_d;
  assign w_turn_ev  = i_turn_side & ~r_turn_d;
  assign w_place_ev = i_place_disk & ~r_place_d;
  assign w_idle     = (r_state == S_IDLE);

  assign w_ny = i_move_up ? f_dec(r_y) : i_move_down ? f_inc(r_y) : r_y;
  assign w_nx = (i_move_up | i_move_down) ? r_x :
                i_move_left ? f_dec(r_x) : i_move_right ? f_inc(r_x) : r_x;
  assign w_moved = (w_nx != r_x) | (w_ny != r_y);

  assign w_cur_idx  = IW'(32'(r_y) * BOARD_DIM + 32'(r_x));
  assign w_cell_cur = r_cells[w_cur_idx];
  assign w_place_go = w_idle & w_place_ev & ~w_mv_ev & (w_cell_cur == 2'b00);

  // every job plots the current cursor cell: ERASE is entered before x/y take the new value
  assign w_xp = XPW'(X_ORIGIN + PITCH * 32'(r_x));
  assign w_yp = YPW'(Y_ORIGIN + PITCH * 32'(r_y));

  assign w_rd_in  = (32'(i_rd_x) < BOARD_DIM) && (32'(i_rd_y) < BOARD_DIM);
  assign w_rd_idx = IW'(32'(i_rd_y) * BOARD_DIM + 32'(i_rd_x));
  assign o_rd_state = w_rd_in ? r_cells[w_rd_idx] : 2'b00;

  assign o_x            = r_x;
  assign o_y            = r_y;
  assign o_old_x        = r_old_x;
  assign o_old_y        = r_old_y;
  assign o_side         = r_side;
  assign o_place_reject = r_rej;
  assign o_busy         = ~w_idle;
  assign plot_if.x_plot     = r_xp;
  assign plot_if.y_plot     = r_yp;
  assign plot_if.select     = r_sel;
  assign plot_if.plot_valid = r_pv;

  // previous-cycle samples for rising-edge detection of the command inputs
  always_ff @(posedge clock) begin
    if (resetn) {r_mv_d, r_turn_d, r_place_d} <= 3'b000;
    else {r_mv_d, r_turn_d, r_place_d} <= {w_mv_any, i_turn_side, i_place_disk};
  end

  // side toggles on every turn event regardless of FSM state
  always_ff @(posedge clock) begin
    if (resetn) r_side <= 1'b0;
    else if (w_turn_ev) r_side <= ~r_side;
  end

  // job sequencer: accepts commands in IDLE and registers plot outputs together with the state change
  always_ff @(posedge clock) begin
    if (resetn) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_old_x <= '0;
      r_old_y <= '0;
      r_xp    <= '0;
      r_yp    <= '0;
      r_sel   <= 2'b00;
      r_pv    <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_rej <= 1'b0;
      if (w_idle) begin
        if (w_mv_ev) begin
          if (w_moved) begin
            r_old_x <= r_x;
            r_old_y <= r_y;
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_state <= S_ERASE;
            r_pv    <= 1'b1;
            r_xp    <= w_xp;
            r_yp    <= w_yp;
            r_sel   <= 2'b00;
          end
        end else if (w_place_ev) begin
          if (w_place_go) begin
            r_state <= S_DISK;
            r_pv    <= 1'b1;
            r_xp    <= w_xp;
            r_yp    <= w_yp;
            r_sel   <= {1'b1, r_side};
          end else begin
            r_rej <= 1'b1;
          end
        end
      end else if (plot_if.plot_ready) begin
        if (r_state == S_ERASE) begin
          r_state <= S_BOX;
          r_xp    <= w_xp;
          r_yp    <= w_yp;
          r_sel   <= 2'b01;
        end else begin
          r_state <= S_IDLE;
          r_pv    <= 1'b0;
        end
      end
    end
  end

  // cell-state array with a single placement write port
  always_ff @(posedge clock) begin
    if (resetn) begin
      r_cells <= '{default: 2'b00};
`ifdef OTHELLO_INIT_BOARD_EN
      r_cells[I_LL] <= 2'b11;
      r_cells[I_HH] <= 2'b11;
      r_cells[I_HL] <= 2'b10;
      r_cells[I_LH] <= 2'b10;
`else
`endif
    end else if (w_place_go) begin
      r_cells[w_cur_idx] <= {1'b1, r_side};
    end
  end
endmodule

// File: tb/tb_othello_cursor_datapath.sv
// tb_othello_cursor_datapath: clamp and wrap instances driven by shared random commands, jobs checked through a scoreboard
module tb_othello_cursor_datapath;
  localparam int N = 8, CW = 3, PITCH = 13, XO = 9, YO = 9, XPW = 8, YPW = 7;

  typedef struct packed {
    logic [XPW-1:0] xp;
    logic [YPW-1:0] yp;
    logic [1:0]     sel;
  } job_t;

  logic clk = 1'b0, resetn = 1'b1;
  logic mu = 0, md = 0, ml = 0, mr = 0, ts = 0, pd = 0, prdy = 0;
  logic [CW-1:0] qx = '0, qy = '0;
  logic [1:0] rs0, rs1;
  logic [CW-1:0] x0, y0, ox0, oy0, x1, y1, ox1, oy1;
  logic side0, side1, rej0, rej1, busy0, busy1;

  othello_cursor_datapath_if #(.XPW(XPW), .YPW(YPW)) if0 ();
  othello_cursor_datapath_if #(.XPW(XPW), .YPW(YPW)) if1 ();
  assign if0.plot_ready = prdy;
  assign if1.plot_ready = prdy;

  othello_cursor_datapath #(.WRAP(0)) dut0 (
    .clock(clk), .resetn(resetn), .i_move_up(mu), .i_move_down(md), .i_move_left(ml),
    .i_move_right(mr), .i_turn_side(ts), .i_place_disk(pd), .i_rd_x(qx), .i_rd_y(qy),
    .o_rd_state(rs0), .o_x(x0), .o_y(y0), .o_old_x(ox0), .o_old_y(oy0), .o_side(side0),
    .o_place_reject(rej0), .o_busy(busy0), .plot_if(if0));

  othello_cursor_datapath #(.WRAP(1)) dut1 (
    .clock(clk), .resetn(resetn), .i_move_up(mu), .i_move_down(md), .i_move_left(ml),
    .i_move_right(mr), .i_turn_side(ts), .i_place_disk(pd), .i_rd_x(qx), .i_rd_y(qy),
    .o_rd_state(rs1), .o_x(x1), .o_y(y1), .o_old_x(ox1), .o_old_y(oy1), .o_side(side1),
    .o_place_reject(rej1), .o_busy(busy1), .plot_if(if1));

  always #5 clk = ~clk;

  job_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int mx[2], my[2], mox[2], moy[2];
  logic mside;
  logic [1:0] mcell [2][N][N];
  int rej_cnt[2], rej_exp[2];
  logic pv[2], pr[2];
  job_t pj[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic job_t mk(input int c, input int r, input int sel);
    job_t j;
    j.xp  = XPW'((XO + PITCH * c) % (1 << XPW));
    j.yp  = YPW'((YO + PITCH * r) % (1 << YPW));
    j.sel = 2'(sel);
    return j;
  endfunction

  task automatic push(input int d, input job_t j);
    if (d == 0) q0.push_back(j);
    else q1.push_back(j);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; mox[d] = 0; moy[d] = 0; rej_exp[d] = 0;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++) mcell[d][a][b] = 2'b00;
`ifdef OTHELLO_INIT_BOARD_EN
      mcell[d][N/2-1][N/2-1] = 2'b11;
      mcell[d][N/2][N/2]     = 2'b11;
      mcell[d][N/2][N/2-1]   = 2'b10;
      mcell[d][N/2-1][N/2]   = 2'b10;
`endif
    end
    mside = 1'b0;
  endtask

  // instance 0 clamps at the edges, instance 1 wraps
  task automatic model_move(input int dx, input int dy);
    for (int d = 0; d < 2; d++) begin
      int nx = mx[d] + dx, ny = my[d] + dy;
      if (nx < 0) nx = (d == 1) ? N - 1 : mx[d];
      if (nx >= N) nx = (d == 1) ? 0 : mx[d];
      if (ny < 0) ny = (d == 1) ? N - 1 : my[d];
      if (ny >= N) ny = (d == 1) ? 0 : my[d];
      if (nx != mx[d] || ny != my[d]) begin
        push(d, mk(mx[d], my[d], 0));
        push(d, mk(nx, ny, 1));
        mox[d] = mx[d]; moy[d] = my[d]; mx[d] = nx; my[d] = ny;
      end
    end
  endtask

  task automatic model_place();
    for (int d = 0; d < 2; d++) begin
      if (mcell[d][mx[d]][my[d]] == 2'b00) begin
        mcell[d][mx[d]][my[d]] = {1'b1, mside};
        push(d, mk(mx[d], my[d], 2 + int'(mside)));
      end else rej_exp[d]++;
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r, input job_t j);
    job_t e;
    if (pv[d] && !pr[d]) begin
      chk($sformatf("hold_valid%0d", d), int'(v), 1);
      chk($sformatf("hold_job%0d", d), int'(j), int'(pj[d]));
    end
    if (v && r) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_job%0d: got x=%0d y=%0d sel=%0d expected no job", d, j.xp, j.yp, j.sel);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("job_x%0d", d), int'(j.xp), int'(e.xp));
        chk($sformatf("job_y%0d", d), int'(j.yp), int'(e.yp));
        chk($sformatf("job_sel%0d", d), int'(j.sel), int'(e.sel));
      end
    end
    pv[d] = v; pr[d] = r; pj[d] = j;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      pv[0] = 1'b0; pv[1] = 1'b0; rej_cnt[0] = 0; rej_cnt[1] = 0;
    end else begin
      mon(0, if0.plot_valid, if0.plot_ready, {if0.x_plot, if0.y_plot, if0.select});
      mon(1, if1.plot_valid, if1.plot_ready, {if1.x_plot, if1.y_plot, if1.select});
      if (rej0) rej_cnt[0]++;
      if (rej1) rej_cnt[1]++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      prdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while ((busy0 || busy1) && n < 400);
    if (busy0 || busy1) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=%0d%0d expected 00", busy0, busy1);
    end
  endtask

  task automatic press(input logic [5:0] m, input int hold);
    {pd, ts, mr, ml, md, mu} = m;
    for (int i = 0; i < hold; i++) begin
      prdy = 1'($urandom_range(0, 1));
      tick();
    end
    {pd, ts, mr, ml, md, mu} = 6'b0;
    wait_idle();
  endtask

  task automatic do_op(input int k, input int hold);
    case (k)
      0: begin model_move(0, -1); press(6'b000001, hold); end
      1: begin model_move(0, 1);  press(6'b000010, hold); end
      2: begin model_move(-1, 0); press(6'b000100, hold); end
      3: begin model_move(1, 0);  press(6'b001000, hold); end
      4: begin mside = ~mside;    press(6'b010000, hold); end
      5: begin model_place();     press(6'b100000, hold); end
      default: begin model_move(1, 0); press(6'b101000, hold); end
    endcase
  endtask

  task automatic check_state();
    chk("x0", int'(x0), mx[0]);     chk("y0", int'(y0), my[0]);
    chk("old_x0", int'(ox0), mox[0]); chk("old_y0", int'(oy0), moy[0]);
    chk("x1", int'(x1), mx[1]);     chk("y1", int'(y1), my[1]);
    chk("old_x1", int'(ox1), mox[1]); chk("old_y1", int'(oy1), moy[1]);
    chk("side0", int'(side0), int'(mside)); chk("side1", int'(side1), int'(mside));
    chk("busy0", int'(busy0), 0);   chk("busy1", int'(busy1), 0);
    chk("rejects0", rej_cnt[0], rej_exp[0]); chk("rejects1", rej_cnt[1], rej_exp[1]);
    qx = CW'($urandom_range(0, N - 1));
    qy = CW'($urandom_range(0, N - 1));
    #1;
    chk("rd_state0", int'(rs0), int'(mcell[0][qx][qy]));
    chk("rd_state1", int'(rs1), int'(mcell[1][qx][qy]));
  endtask

  task automatic do_reset();
    prdy = 1'b0;
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
  endtask

  task automatic check_reset();
    chk("rst_valid0", int'(if0.plot_valid), 0); chk("rst_valid1", int'(if1.plot_valid), 0);
    chk("rst_xplot0", int'(if0.x_plot), 0);     chk("rst_yplot0", int'(if0.y_plot), 0);
    chk("rst_select0", int'(if0.select), 0);    chk("rst_reject0", int'(rej0), 0);
    check_state();
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        qx = CW'(a); qy = CW'(b);
        #1;
        chk("rst_cell0", int'(rs0), int'(mcell[0][a][b]));
        chk("rst_cell1", int'(rs1), int'(mcell[1][a][b]));
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();
    check_reset();

    do_op(2, 1);
    chk("wrap_left_x1", int'(x1), 7);
    chk("clamp_left_x0", int'(x0), 0);
    check_state();

    model_move(0, -1);
    mu = 1'b1;
    tick();
    mu = 1'b0;
    chk("clamp_up_busy0", int'(busy0), 0);
    chk("clamp_up_valid0", int'(if0.plot_valid), 0);
    wait_idle();
    check_state();

    do_reset();
    do_op(3, 5);
    chk("held_right_x0", int'(x0), 1);
    chk("held_right_old0", int'(ox0), 0);
    check_state();

    do_reset();
    for (int i = 0; i < 3; i++) do_op(3, 1);
    for (int i = 0; i < 4; i++) do_op(1, 1);
    do_op(4, 1);
    do_op(5, 1);
    qx = 3; qy = 4;
    #1;
    chk("disk_cell0", int'(rs0), 3);
    check_state();
    do_op(5, 2);
    chk("reject_pulse0", rej_cnt[0], 1);
    check_state();

    do_reset();
    model_move(1, 0);
    mr = 1'b1;
    tick();
    mr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      md = (i == 2);
      pd = (i == 5);
      tick();
      chk("stall_busy0", int'(busy0), 1);
      chk("stall_valid1", int'(if1.plot_valid), 1);
    end
    md = 1'b0; pd = 1'b0;
    wait_idle();
    check_state();

    do_reset();
    model_move(1, 0);
    mr = 1'b1;
    tick();
    mr = 1'b0;
    tick();
    prdy = 1'b1;
    tick();
    prdy = 1'b0;
    tick();
    chk("box_valid0", int'(if0.plot_valid), 1);
    chk("box_select0", int'(if0.select), 1);
    do_reset();
    check_reset();

    for (int i = 0; i < 300; i++) begin
      do_op(int'($urandom_range(0, 6)), int'($urandom_range(1, 4)));
      check_state();
    end

    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
